// File: rtl/router_fifo_pkg.sv
// rtl/router_fifo_pkg.sv - shared types, defaults and header-length helper for the packet FIFO
package router_fifo_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int LEN_LSB_DEF = 2;
  localparam int LEN_W_DEF   = 6;

  typedef enum logic {
    RD_HDR  = 1'b0,
    RD_BODY = 1'b1
  } rd_state_t;

  // Generic so any DATA_W/LEN_LSB/LEN_W instance can reuse it; callers narrow the result.
  function automatic logic [63:0] len_of(input logic [63:0] word, input int lsb, input int w);
    return (word >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// rtl/router_fifo_ram.sv - (DATA_W+1) x DEPTH storage, synchronous write and read, no reset
module router_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware channel FIFO with header/EOP tracking on the read side
// Optional ROUTER_PKT_FIFO_STATS_EN adds occupancy and pkt_count outputs.
module router_pkt_fifo
  import router_fifo_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LEN_LSB = LEN_LSB_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              sop_out,
  output logic              eop_out,
  output logic              hdr_err,
  output logic              full,
  output logic              empty
`ifdef ROUTER_PKT_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] pkt_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic             flush, wr_fire, rd_fire, have_rd;
  logic [DATA_W:0]  ram_q;
  logic             word_tag;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W:0]   rem, rem_nxt;
  rd_state_t        state, state_nxt;

  assign flush   = !resetn || soft_reset;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_fire = write_enb && !full && !flush;
  assign rd_fire = read_enb && !empty && !flush;

  router_fifo_ram #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock   (clock),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({lfd_state, data_in}),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM output is unreset; have_rd forces data_out to 0 until the first pop after resetn.
  always_ff @(posedge clock) begin
    if (!resetn)      have_rd <= 1'b0;
    else if (rd_fire) have_rd <= 1'b1;
  end

  assign data_out = have_rd ? ram_q[DATA_W-1:0] : '0;
  assign word_tag = ram_q[DATA_W];
  assign hdr_len  = LEN_W'(len_of(64'(ram_q[DATA_W-1:0]), LEN_LSB, LEN_W));

  always_ff @(posedge clock) begin
    if (flush) begin
      data_valid <= 1'b0;
      state      <= RD_HDR;
      rem        <= '0;
    end else begin
      data_valid <= rd_fire;
      state      <= state_nxt;
      rem        <= rem_nxt;
    end
  end

  // Word popped last cycle is classified here, while it sits on data_out.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    sop_out   = 1'b0;
    eop_out   = 1'b0;
    hdr_err   = 1'b0;
    if (data_valid) begin
      if (word_tag) begin
        sop_out   = 1'b1;
        hdr_err   = (state == RD_BODY);
        rem_nxt   = {1'b0, hdr_len} + (LEN_W + 1)'(1);
        state_nxt = RD_BODY;
      end else if (state == RD_HDR) begin
        hdr_err = 1'b1;
      end else begin
        if (rem != '0) rem_nxt = rem - 1'b1;
        if (rem <= (LEN_W + 1)'(1)) begin
          eop_out   = (rem == (LEN_W + 1)'(1));
          state_nxt = RD_HDR;
        end
      end
    end
  end

`ifdef ROUTER_PKT_FIFO_STATS_EN
  logic [LEN_W:0] wr_rem;
  logic           pkt_inc, pkt_dec;

  assign occupancy = wr_ptr - rd_ptr;
  assign pkt_inc   = wr_fire && !lfd_state && (wr_rem == (LEN_W + 1)'(1));
  assign pkt_dec   = eop_out && (pkt_count != '0);

  // Independent write-side length parser so packets are counted as their parity byte lands.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_rem    <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_fire) begin
        if (lfd_state)
          wr_rem <= {1'b0, LEN_W'(len_of(64'(data_in), LEN_LSB, LEN_W))} + (LEN_W + 1)'(1);
        else if (wr_rem != '0)
          wr_rem <= wr_rem - 1'b1;
      end
      if (pkt_inc && !pkt_dec)      pkt_count <= pkt_count + 1'b1;
      else if (!pkt_inc && pkt_dec) pkt_count <= pkt_count - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - scoreboard bench for router_pkt_fifo
module tb_router_pkt_fifo;

  localparam int DEPTH = 16;

  logic       clock, resetn, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in, data_out;
  logic       data_valid, sop_out, eop_out, hdr_err, full, empty;
`ifdef ROUTER_PKT_FIFO_STATS_EN
  logic [4:0] occupancy, pkt_count;
`endif

  router_pkt_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sop_out    (sop_out),
    .eop_out    (eop_out),
    .hdr_err    (hdr_err),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_PKT_FIFO_STATS_EN
    ,
    .occupancy  (occupancy),
    .pkt_count  (pkt_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         occ = 0;
  logic       m_body = 1'b0;
  int         m_rem = 0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Read-side packet parser model, applied in write order since reads follow it exactly.
  task automatic model_push(input logic tag, input logic [7:0] d);
    exp_t e;
    e.d = d; e.sop = 1'b0; e.eop = 1'b0; e.err = 1'b0;
    if (tag) begin
      e.sop  = 1'b1;
      e.err  = m_body;
      m_rem  = int'((d >> 2) & 8'h3F) + 1;
      m_body = 1'b1;
    end else if (!m_body) begin
      e.err = 1'b1;
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        e.eop  = 1'b1;
        m_body = 1'b0;
      end
    end
    sb.push_back(e);
  endtask

  task automatic model_clear();
    sb.delete();
    occ    = 0;
    m_body = 1'b0;
    m_rem  = 0;
  endtask

  task automatic step(input logic we, input logic lfd, input logic [7:0] din, input logic re);
    exp_t e;
    logic wf, rf;
    write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;
    wf = we && (occ < DEPTH);
    rf = re && (occ > 0);
    if (wf) model_push(lfd, din);
    @(posedge clock); #1;
    if (rf) begin
      e = sb.pop_front();
      check("valid", 32'(data_valid), 32'd1);
      check("data", 32'(data_out), 32'(e.d));
      check("sop", 32'(sop_out), 32'(e.sop));
      check("eop", 32'(eop_out), 32'(e.eop));
      check("hdr_err", 32'(hdr_err), 32'(e.err));
      last_data = e.d;
    end else begin
      check("valid_idle", 32'(data_valid), 32'd0);
      check("data_hold", 32'(data_out), 32'(last_data));
      check("flags_idle", {29'd0, sop_out, eop_out, hdr_err}, 32'd0);
    end
    occ = occ + int'(wf) - int'(rf);
    check("empty", 32'(empty), 32'(occ == 0));
    check("full", 32'(full), 32'(occ == DEPTH));
`ifdef ROUTER_PKT_FIFO_STATS_EN
    check("occupancy", 32'(occupancy), 32'(occ));
`endif
    write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; write_enb = 1'b1; read_enb = 1'b1;
    @(posedge clock); #1;
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    resetn = 1'b1; write_enb = 1'b0; read_enb = 1'b0;
    model_clear();
    last_data = 8'h00;
  endtask

  task automatic do_soft_reset();
    soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hEE;
    @(posedge clock); #1;
    check("srst_empty", 32'(empty), 32'd1);
    check("srst_valid", 32'(data_valid), 32'd0);
    check("srst_data_hold", 32'(data_out), 32'(last_data));
    check("srst_flags", {29'd0, sop_out, eop_out, hdr_err}, 32'd0);
    soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    model_clear();
  endtask

  initial begin
    clock = 1'b0; resetn = 1'b0; soft_reset = 1'b0;
    write_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00; read_enb = 1'b0;

    // 1: one len-3 packet through
    do_reset();
    step(1, 1, 8'h0C, 0);
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    step(1, 0, 8'h99, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
    check("t1_empty", 32'(empty), 32'd1);

    // 2: fill to full, drop a write, drain in order
    do_reset();
    step(1, 1, 8'h38, 0);
    for (int i = 1; i < 16; i++) step(1, 0, 8'(8'h40 + i), 0);
    step(1, 1, 8'hAB, 0);
    check("t2_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);

    // 3: steady concurrent read/write at half occupancy
    do_reset();
    for (int i = 0; i < 8; i++) step(1, (i % 5) == 0, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 20; i++) step(1, (i % 4) == 0, 8'($urandom_range(0, 255)), 1);
`ifdef ROUTER_PKT_FIFO_STATS_EN
    check("t3_occupancy", 32'(occupancy), 32'd8);
`endif
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);

    // 4: untagged word while expecting a header
    do_reset();
    step(1, 0, 8'h55, 0);
    step(1, 1, 8'h04, 0);
    step(1, 0, 8'hA1, 0);
    step(1, 0, 8'hA2, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

    // 5: soft reset mid-packet then a clean packet
    do_reset();
    step(1, 1, 8'h0C, 0);
    for (int i = 1; i < 5; i++) step(1, 0, 8'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    do_soft_reset();
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h08, 0);
    step(1, 0, 8'h61, 0);
    step(1, 0, 8'h62, 0);
    step(1, 0, 8'h6F, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

`ifdef ROUTER_PKT_FIFO_STATS_EN
    // 6: packet statistics
    do_reset();
    step(1, 1, 8'h04, 0);
    step(1, 0, 8'h10, 0);
    step(1, 0, 8'h1F, 0);
    step(1, 1, 8'h08, 0);
    step(1, 0, 8'h20, 0);
    step(1, 0, 8'h21, 0);
    step(1, 0, 8'h2F, 0);
    check("t6_pkt2", 32'(pkt_count), 32'd2);
    check("t6_occ7", 32'(occupancy), 32'd7);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    check("t6_pkt1", 32'(pkt_count), 32'd1);
    check("t6_occ4", 32'(occupancy), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
